muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit; the multi-cycle execution path beside the single-cycle ALU in the execute stage. It accepts two 32-bit operands plus an M-extension funct3 over a valid/ready request handshake. It computes the result serially, one bit per cycle, and returns it over a valid/ready response handshake. The pipeline stalls on req_ready/resp_valid; the unit never blocks the ALU path.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
src_a  input  XLEN  operand A (multiplicand / dividend)
src_b  input  XLEN  operand B (multiplier / divisor)
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
kill  input  1  abort the in-flight operation (pipeline flush)
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
result  output  XLEN  operation result

Behaviour:
- Reset is synchronous, on the rising clk edge with reset=1:
  - state=IDLE, req_ready=1, resp_valid=0, result=0, internal accumulators and counter=0.
  - Reset mid-operation discards all work; no response is produced.
- States:
  - IDLE: req_ready=1. A request is accepted when req_valid&&req_ready. On acceptance, latch funct3, operand signs and magnitudes.
    - Next state is CALC, or DONE directly for special divide cases.
  - CALC: req_ready=0. Run one iteration per cycle, with the counter running XLEN-1 down to 0. At counter==0 go to FIX.
  - FIX: apply sign correction, select the high/low product half or the quotient/remainder, and register result. Next state is DONE.
  - DONE: resp_valid=1 and result holds stable. On resp_ready, go to IDLE.
- Latency:
  - Normal operation: resp_valid rises XLEN+2 cycles after the acceptance edge (34 for XLEN=32).
  - Special cases: resp_valid rises 1 cycle after acceptance.
- Multiply:
  - Use radix-2 shift-add on unsigned magnitudes into a 2*XLEN product register.
  - Operand signedness: MUL/MULH treat both operands as signed; MULHSU treats A as signed and B as unsigned; MULHU treats both as unsigned.
  - FIX negates the product (two's complement, 2*XLEN wide) when the result sign is negative.
  - MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- Divide:
  - Use restoring division on magnitudes: shift, trial-subtract, set quotient bit.
  - Quotient sign = sign(A) XOR sign(B) (signed ops only).
  - Remainder sign = sign(A) (signed ops only).
- Special cases, taken straight to DONE with no iteration:
  - Divisor zero: DIV/DIVU return all ones; REM/REMU return src_a.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Kill:
  - kill=1 in CALC, FIX or DONE returns the unit to IDLE on the next edge. resp_valid is deasserted, and no response is delivered.
  - kill in IDLE blocks acceptance in that same cycle.
  - reset takes priority over kill.
- Response rules: result changes only on entry to DONE. resp_valid holds until resp_ready, regardless of how long the consumer stalls.
- Back-to-back requests: there is no overlap. The next request is accepted only in IDLE, at the earliest one cycle after the response handshake.
- Operand changes on src_a, src_b or funct3 after acceptance have no effect.

Test Plan:
- MUL with src_a=7, src_b=0xFFFFFFFD (-3) -> after 34 cycles, result=0xFFFFFFEB; resp_valid held through 5 cycles of resp_ready=0.
- MULH with 0x80000000 x 0x80000000 -> 0x40000000. MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with 34-cycle latency.
- DIVU 100/0 -> 0xFFFFFFFF and REM 100/0 -> 100, with 1-cycle latency. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same operands -> 0.
- kill asserted at CALC cycle 10 -> IDLE next cycle and no resp_valid. A following MUL 3x5 -> 15 with full latency.
- reset asserted in DONE with resp_ready=0 -> next edge gives resp_valid=0, req_ready=1, result=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [2:0]      funct3,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] opnd;
  logic            res_neg;
  logic            a_neg;

  logic            accept;
  logic            a_sign, b_sign;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_result;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quot_fixed;
  logic [XLEN-1:0]   rem_fixed;
  logic [XLEN-1:0]   fix_result;

  assign accept = req_valid && req_ready && !kill;

  // Divide ops are signed when funct3[0]==0; multiply signedness follows MUL/MULH/MULHSU/MULHU.
  assign a_sign = funct3[2] ? (!funct3[0] && src_a[XLEN-1])
                            : ((funct3[1:0] != 2'b11) && src_a[XLEN-1]);
  assign b_sign = funct3[2] ? (!funct3[0] && src_b[XLEN-1])
                            : (!funct3[1] && src_b[XLEN-1]);
  assign a_mag  = a_sign ? -src_a : src_a;
  assign b_mag  = b_sign ? -src_b : src_b;

  assign div_zero = funct3[2] && (src_b == '0);
  assign div_ovf  = funct3[2] && !funct3[0]
                    && (src_a == {1'b1, {(XLEN-1){1'b0}}})
                    && (src_b == {XLEN{1'b1}});
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = funct3[1] ? src_a : {XLEN{1'b1}};
    else if (div_ovf)
      special_result = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Multiply: acc_hi accumulates, acc_lo holds the multiplier and shifts out from the bottom.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  assign product    = {acc_hi, acc_lo};
  assign prod_fixed = res_neg ? -product : product;
  assign quot_fixed = res_neg ? -acc_lo : acc_lo;
  assign rem_fixed  = a_neg ? -acc_hi : acc_hi;

  always_comb begin
    fix_result = '0;
    case (op)
      3'b000:                 fix_result = prod_fixed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fixed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quot_fixed;
      default:                fix_result = rem_fixed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (cnt == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill && (state != IDLE))
      state_next = IDLE;
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      op      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      res_neg <= 1'b0;
      a_neg   <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op      <= funct3;
            cnt     <= CW'(XLEN-1);
            acc_hi  <= '0;
            acc_lo  <= funct3[2] ? a_mag : b_mag;
            opnd    <= funct3[2] ? b_mag : a_mag;
            res_neg <= a_sign ^ b_sign;
            a_neg   <= a_sign;
            if (special)
              result <= special_result;
          end
        end
        CALC: begin
          if (cnt != '0)
            cnt <= cnt - CW'(1);
          if (op[2]) begin
            if (!div_diff[XLEN]) begin
              acc_hi <= div_diff[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
          end
        end
        FIX: begin
          if (!kill)
            result <= fix_result;
        end
        default: ;
      endcase
    end
  end

endmodule
